sar_search: RTL



---
 rtl/sar_search_if.sv | 37 +++
 rtl/sar_search.sv | 70 +++++++
 2 files changed

// File: rtl/sar_search_if.sv
// Handshake bundle between the successive-approximation controller and its
// surroundings (requester plus the combinational a >= b comparator).
//   start  : request a search (driven by the requester)
//   ge     : comparator flag, 1 when target >= trial (driven by the comparator)
//   trial  : value presented on the comparator's b side
//   busy   : search in progress
//   done   : one-cycle pulse when result is updated
//   result : last resolved value
// The controller uses the master modport; the environment uses slave.
interface sar_search_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             ge;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    input  start,
    input  ge,
    output trial,
    output busy,
    output done,
    output result
  );

  modport slave (
    output start,
    output ge,
    input  trial,
    input  busy,
    input  done,
    input  result
  );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search controller. Drives trial values into an
// external a >= b comparator and resolves, MSB first, the largest value not
// exceeding the comparator's unknown a input, one bit per clock.
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous, active-high reset
//   bus : sar_search_if master (start/ge in, trial/busy/done/result out)
// WIDTH must match the WIDTH of the connected interface instance.
module sar_search #(
  parameter int unsigned WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  sar_search_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

  localparam logic [WIDTH-1:0] MsbMask = WIDTH'(1) << (WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mask_q;   // one-hot: bit currently being decided
  logic [WIDTH-1:0] result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mask_q   <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            acc_q   <= '0;
            mask_q  <= MsbMask;
            state_q <= StSearch;
          end
        end
        StSearch: begin
          if (bus.ge) begin
            acc_q <= acc_q | mask_q;
          end
          if (mask_q[0]) begin
            // Last bit: fold the current decision straight into result.
            result_q <= acc_q | (bus.ge ? mask_q : '0);
            state_q  <= StDone;
          end else begin
            mask_q <= mask_q >> 1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs depend on registered state only, so the comparator loop
  // through ge never closes combinationally.
  assign bus.trial  = (state_q == StSearch) ? (acc_q | mask_q) : '0;
  assign bus.busy   = (state_q == StSearch);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;

endmodule
